// File: rtl/key_load_ctrl.sv
// key_load_ctrl
//   Serial unlock-key loader for the locked c432 core. Shifts in KEY_W key
//   bits followed by CHK_W checksum bits (LSB first) and verifies that the
//   checksum equals the XOR of all CHK_W-bit slices of the key. Only a
//   verified key reaches key_out; otherwise key_out stays 0 (a wrong key).
//   Repeated failures (bad checksum or idle timeout) lead to a permanent
//   lockout until reset.
// Ports
//   clk, rst_n   clock (rising edge), async active-low reset
//   start        one-cycle request to begin a key load
//   key_bit      serial key/checksum bit, accepted on key_bit_vld & key_rdy
//   key_bit_vld  key_bit qualifier
//   key_rdy      high only while loading
//   key_out      verified key (p1..p4 in [3:0], X_1..X_24 in [27:4]) or 0
//   key_valid    sticky: key_out holds a verified key
//   key_err      last load failed, or locked out
//   busy         high while loading or checking
module key_load_ctrl #(
  parameter int KEY_W     = 28,
  parameter int CHK_W     = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_bit,
  input  logic             key_bit_vld,
  output logic             key_rdy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);
  localparam int SH_W = KEY_W + CHK_W;
  localparam int NSL  = KEY_W / CHK_W;
  localparam int BC_W = $clog2(SH_W);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR, LOCKOUT} state_t;

  state_t            state, state_n;
  logic [SH_W-1:0]   shadow;
  logic [BC_W-1:0]   bit_cnt;
  logic [TO_W-1:0]   tmo_cnt;
  logic [RC_W-1:0]   retry_cnt;
  logic [KEY_W-1:0]  key_q;
  logic              vld_q, err_q;
  logic [CHK_W-1:0]  fold;
  logic              match, accept, last_bit, tmo_hit;

  // Shadow fills from the top so the first received bit lands in bit 0:
  // key = shadow[KEY_W-1:0], chk = shadow[SH_W-1 -: CHK_W].
  always_comb begin
    fold = '0;
    for (int i = 0; i < NSL; i++) fold = fold ^ shadow[i*CHK_W +: CHK_W];
  end
  assign match = (fold == shadow[SH_W-1 -: CHK_W]);

  assign accept   = key_bit_vld && (state == LOAD);
  assign last_bit = accept && (bit_cnt == BC_W'(SH_W - 1));
  // Counter is about to reach TIMEOUT on this idle edge.
  assign tmo_hit  = (state == LOAD) && !accept && (tmo_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (last_bit) state_n = CHECK;
               else if (tmo_hit) state_n = ERROR;
      CHECK:   state_n = match ? DONE : ERROR;
      ERROR:   if (retry_cnt == RC_W'(MAX_RETRY)) state_n = LOCKOUT;
               else if (start) state_n = LOAD;
      DONE:    state_n = DONE;
      LOCKOUT: state_n = LOCKOUT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      key_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;

      if (state_n == LOAD && state != LOAD) begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
        tmo_cnt <= '0;
      end else if (state == LOAD) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (accept)              shadow <= {key_bit, shadow[SH_W-1:1]};
      else if (state == ERROR) shadow <= '0;

      if (state_n == ERROR && state != ERROR) begin
        retry_cnt <= retry_cnt + 1'b1;
        err_q     <= 1'b1;
      end else if (state == ERROR && state_n == LOAD) begin
        err_q <= 1'b0;
      end else if (state_n == LOCKOUT) begin
        err_q <= 1'b1;
      end

      if (state == CHECK && match) begin
        key_q <= shadow[KEY_W-1:0];
        vld_q <= 1'b1;
        err_q <= 1'b0;
      end
    end
  end

  assign key_rdy   = (state == LOAD);
  assign busy      = (state == LOAD) || (state == CHECK);
  assign key_out   = key_q;
  assign key_valid = vld_q;
  assign key_err   = err_q;
endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point (away from the edge).
module tb_key_load_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_bit_vld = 1'b0;
  logic        key_rdy, key_valid, key_err, busy;
  logic [27:0] key_out;

  int checks = 0;
  int errors = 0;

  // Fold-XOR checksums worked by hand:
  //   28'h0A5C3F1: 0^A^5^C^3^F^1 = E ;  28'h1234567: 1^2^3^4^5^6^7 = 0
  localparam logic [27:0] KEY_A = 28'h0A5C3F1;
  localparam logic [3:0]  CHK_A = 4'hE;
  localparam logic [27:0] KEY_B = 28'h1234567;
  localparam logic [3:0]  CHK_B = 4'h0;
  localparam logic [27:0] KEY_C = 28'hBEEF123;

  key_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_bit(key_bit),
    .key_bit_vld(key_bit_vld), .key_rdy(key_rdy), .key_out(key_out),
    .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; key_bit_vld = 1'b0; key_bit = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Send the 32-bit frame {chk,key} LSB first. gaps=1 inserts idle cycles
  // (all well below the timeout) and raises start alongside some bits,
  // including the final one.
  task automatic send_frame(input logic [27:0] k, input logic [3:0] c, input bit gaps);
    logic [31:0] w;
    w = {c, k};
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        start = (i % 4 == 1);
        tick((i * 7) % 13);
        start = 1'b0;
      end
      key_bit = w[i];
      key_bit_vld = 1'b1;
      start = gaps && ((i % 5 == 0) || (i == 31));
      tick(1);
      key_bit_vld = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_out, key_valid, key_err, busy, key_rdy} !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got key_out=%h valid=%b err=%b busy=%b rdy=%b, want all 0",
               key_out, key_valid, key_err, busy, key_rdy);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    checks++;
    if (key_rdy !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_to_load: got rdy=%b busy=%b, want 1 1", key_rdy, busy);
    end
  endtask

  task automatic test_good_load();
    do_reset();
    pulse_start();
    send_frame(KEY_A, CHK_A, 1'b0);
    // In CHECK: not yet valid, rdy dropped, still busy.
    checks++;
    if (key_valid !== 1'b0 || key_rdy !== 1'b0 || busy !== 1'b1 || key_out !== 28'h0) begin
      errors++;
      $display("FAIL check_cycle: got valid=%b rdy=%b busy=%b key_out=%h, want 0 0 1 0000000",
               key_valid, key_rdy, busy, key_out);
    end
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key_out !== KEY_A || key_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_load: got valid=%b key_out=%h err=%b busy=%b, want 1 %h 0 0",
               key_valid, key_out, key_err, busy, KEY_A);
    end
  endtask

  task automatic test_bad_lockout();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      checks++;
      if (key_err !== 1'b0 || key_rdy !== 1'b1) begin
        errors++;
        $display("FAIL retry_start_%0d: got err=%b rdy=%b, want 0 1", r, key_err, key_rdy);
      end
      send_frame(KEY_A, 4'h8, 1'b0);
      tick(1);
      checks++;
      if (key_err !== 1'b1 || key_out !== 28'h0 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad_chk_%0d: got err=%b key_out=%h valid=%b, want 1 0000000 0",
                 r, key_err, key_out, key_valid);
      end
    end
    tick(1);
    pulse_start();
    tick(2);
    checks++;
    if (key_rdy !== 1'b0 || busy !== 1'b0 || key_err !== 1'b1 || key_out !== 28'h0) begin
      errors++;
      $display("FAIL lockout: got rdy=%b busy=%b err=%b key_out=%h, want 0 0 1 0000000",
               key_rdy, busy, key_err, key_out);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    do_reset();
    pulse_start();
    w = {CHK_A, KEY_A};
    for (int i = 0; i <= 10; i++) begin
      key_bit = w[i]; key_bit_vld = 1'b1;
      tick(1);
      key_bit_vld = 1'b0;
    end
    tick(63);
    checks++;
    if (key_err !== 1'b0 || key_rdy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_63: got err=%b rdy=%b, want 0 1", key_err, key_rdy);
    end
    tick(1);
    checks++;
    if (key_err !== 1'b1 || key_rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_64: got err=%b rdy=%b busy=%b, want 1 0 0", key_err, key_rdy, busy);
    end
    pulse_start();
    send_frame(KEY_A, CHK_A, 1'b0);
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key_out !== KEY_A || key_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got valid=%b key_out=%h err=%b, want 1 %h 0",
               key_valid, key_out, key_err, KEY_A);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] w;
    do_reset();
    pulse_start();
    w = {CHK_B, KEY_B};
    for (int i = 0; i < 15; i++) begin
      key_bit = w[i]; key_bit_vld = 1'b1;
      tick(1);
      key_bit_vld = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_out, key_valid, key_err, busy, key_rdy} !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: got key_out=%h valid=%b err=%b busy=%b rdy=%b, want all 0",
               key_out, key_valid, key_err, busy, key_rdy);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    send_frame(KEY_B, CHK_B, 1'b0);
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key_out !== KEY_B) begin
      errors++;
      $display("FAIL midload_fresh: got valid=%b key_out=%h, want 1 %h", key_valid, key_out, KEY_B);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    pulse_start();
    send_frame(KEY_B, CHK_B, 1'b1);
    checks++;
    if (busy !== 1'b1 || key_rdy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_check: got busy=%b rdy=%b, want 1 0", busy, key_rdy);
    end
    tick(1);
    checks++;
    if (key_valid !== 1'b1 || key_out !== KEY_B || key_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_load: got valid=%b key_out=%h err=%b, want 1 %h 0",
               key_valid, key_out, key_err, KEY_B);
    end
  endtask

  // Continues from the DONE state left by test_gaps.
  task automatic test_after_done();
    pulse_start();
    send_frame(KEY_C, 4'h3, 1'b0);
    tick(3);
    checks++;
    if (key_valid !== 1'b1 || key_out !== KEY_B || key_rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got valid=%b key_out=%h rdy=%b busy=%b, want 1 %h 0 0",
               key_valid, key_out, key_rdy, busy, KEY_B);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_lockout();
    test_timeout();
    test_reset_midload();
    test_gaps();
    test_after_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
